// File: rtl/appliance_cmd_scheduler_if.sv
// Request/command bundle between the request source and the appliance scheduler.
// drop exists only when PENDING_TIMEOUT_EN is defined.
interface appliance_cmd_scheduler_if;
  logic [4:0] on_req;
  logic [4:0] off_req;
  logic       fridge_cmd;
  logic       oven_cmd;
  logic       coffee_maker_cmd;
  logic       washer_cmd;
  logic       dishwasher_cmd;
  logic [4:0] pending;
  logic [2:0] active_count;
  logic       busy;
`ifdef PENDING_TIMEOUT_EN
  logic [4:0] drop;
`endif

  modport master (
`ifdef PENDING_TIMEOUT_EN
    input  drop,
`endif
    output on_req, off_req,
    input  fridge_cmd, oven_cmd, coffee_maker_cmd, washer_cmd, dishwasher_cmd,
    input  pending, active_count, busy
  );

  modport slave (
`ifdef PENDING_TIMEOUT_EN
    output drop,
`endif
    input  on_req, off_req,
    output fridge_cmd, oven_cmd, coffee_maker_cmd, washer_cmd, dishwasher_cmd,
    output pending, active_count, busy
  );
endinterface

// File: rtl/appliance_cmd_scheduler.sv
// Power-budgeted, staggered turn-on scheduler for five appliance command levels.
// Optional macro PENDING_TIMEOUT_EN adds per-appliance pending age-out with drop pulses.
module appliance_cmd_scheduler #(
  parameter int MAX_ACTIVE     = 2,
  parameter int STAGGER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  appliance_cmd_scheduler_if.slave   bus
);
  localparam int         CW    = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [2:0] MAX_A = 3'(MAX_ACTIVE);

  typedef enum logic {IDLE, HOLDOFF} state_t;

  state_t          state;
  logic [CW-1:0]   stag_cnt;
  logic            busy_q;
  logic [4:0]      cmd;
  logic [4:0]      pending_q;
  logic [4:0]      set_vec;
  logic [4:0]      grant_vec;
  logic [4:0]      timeout_vec;
  logic [2:0]      active_cnt;
  logic            grant_ok;

  always_comb begin
    active_cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      active_cnt = active_cnt + {2'b00, cmd[i]};
    end
  end

  // Budget is judged on the pre-edge cmd, so a same-cycle off never frees a slot early.
  always_comb begin
    grant_ok  = (state == IDLE) && (pending_q != 5'd0) && (active_cnt < MAX_A);
    grant_vec = grant_ok ? (pending_q & 5'(~pending_q + 5'd1)) : 5'd0;
    set_vec   = bus.on_req & ~cmd & ~pending_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      stag_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state    <= HOLDOFF;
            stag_cnt <= CW'(STAGGER_CYCLES - 1);
            busy_q   <= 1'b1;
          end
        end
        HOLDOFF: begin
          if (stag_cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            stag_cnt <= stag_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // off_req beats both a grant and a new request on the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd       <= 5'd0;
      pending_q <= 5'd0;
    end else begin
      cmd       <= (cmd | grant_vec) & ~bus.off_req;
      pending_q <= (pending_q | set_vec) & ~grant_vec & ~timeout_vec & ~bus.off_req;
    end
  end

`ifdef PENDING_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);

  logic [AW-1:0] age [5];
  logic [4:0]    drop_q;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      timeout_vec[i] = pending_q[i] && (age[i] == AW'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        age[i] <= '0;
      end
      drop_q <= 5'd0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (set_vec[i]) begin
          age[i] <= '0;
        end else if (pending_q[i]) begin
          age[i] <= age[i] + 1'b1;
        end
      end
      drop_q <= timeout_vec & ~grant_vec & ~bus.off_req;
    end
  end

  assign bus.drop = drop_q;
`else
  assign timeout_vec = 5'd0;
`endif

  assign bus.fridge_cmd       = cmd[0];
  assign bus.oven_cmd         = cmd[1];
  assign bus.coffee_maker_cmd = cmd[2];
  assign bus.washer_cmd       = cmd[3];
  assign bus.dishwasher_cmd   = cmd[4];
  assign bus.pending          = pending_q;
  assign bus.active_count     = active_cnt;
  assign bus.busy             = busy_q;
endmodule

// File: tb/tb_appliance_cmd_scheduler.sv
// Bench for appliance_cmd_scheduler: directed table, corner sequences, randomized run vs. timeline model.
module tb_appliance_cmd_scheduler;
  localparam int MAX = 2;
  localparam int S   = 4;
  localparam int T   = 8;
`ifdef PENDING_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  appliance_cmd_scheduler_if bus ();

  appliance_cmd_scheduler #(
    .MAX_ACTIVE(MAX), .STAGGER_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: per-bit state plus a timeline (edges since last grant, edges since pending set).
  logic [4:0] m_cmd, m_pend, m_drop;
  int         m_gap;
  int         since [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_cmd();
    return {bus.dishwasher_cmd, bus.washer_cmd, bus.coffee_maker_cmd, bus.oven_cmd, bus.fridge_cmd};
  endfunction

  task automatic model_reset();
    m_cmd = '0; m_pend = '0; m_drop = '0; m_gap = S;
    for (int i = 0; i < 5; i++) since[i] = 0;
  endtask

  task automatic model_edge(input logic [4:0] on, input logic [4:0] off);
    int k;
    logic [4:0] n_cmd, n_pend, n_drop;
    k = -1;
    if (m_gap >= S && m_pend != 0 && $countones(m_cmd) < MAX) begin
      for (int i = 4; i >= 0; i--) if (m_pend[i]) k = i;
    end
    n_cmd = m_cmd; n_pend = m_pend; n_drop = '0;
    for (int i = 0; i < 5; i++) begin
      if (off[i]) begin
        n_cmd[i] = 0; n_pend[i] = 0;
      end else if (i == k) begin
        n_cmd[i] = 1; n_pend[i] = 0;
      end else if (TO_EN && m_pend[i] && since[i] + 1 == T) begin
        n_pend[i] = 0; n_drop[i] = 1;
      end else if (on[i] && !m_cmd[i] && !m_pend[i]) begin
        n_pend[i] = 1; since[i] = 0;
      end else if (m_pend[i]) begin
        since[i]++;
      end
    end
    m_cmd = n_cmd; m_pend = n_pend; m_drop = n_drop;
    m_gap = (k >= 0) ? 0 : ((m_gap > 1000) ? m_gap : m_gap + 1);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cmd"},     32'(dut_cmd()),         32'(m_cmd));
    chk({tag, "_pending"}, 32'(bus.pending),       32'(m_pend));
    chk({tag, "_count"},   32'(bus.active_count),  32'($countones(m_cmd)));
    chk({tag, "_busy"},    32'(bus.busy),          32'(m_gap < S));
`ifdef PENDING_TIMEOUT_EN
    chk({tag, "_drop"},    32'(bus.drop),          32'(m_drop));
`endif
  endtask

  task automatic step(input logic [4:0] on, input logic [4:0] off, input string tag);
    bus.on_req = on; bus.off_req = off;
    @(posedge clk);
    model_edge(on, off);
    #1;
    check_model(tag);
    bus.on_req = '0; bus.off_req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.on_req = '0; bus.off_req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_model("reset");
  endtask

  typedef struct {
    logic [4:0] on, off, cmd, pend;
    logic       busy;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl [15];

  initial begin
    int fr, ov, hi, dr;
    logic [4:0] on, off;

    tbl[0]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 1'b0, 3'd0};
    tbl[1]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 1'b1, 3'd1};
    tbl[2]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 1'b1, 3'd1};
    tbl[3]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 1'b1, 3'd1};
    tbl[4]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 1'b1, 3'd1};
    tbl[5]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 1'b0, 3'd1};
    tbl[6]  = '{5'b11110, 5'b00000, 5'b00001, 5'b11110, 1'b0, 3'd1};
    tbl[7]  = '{5'b00000, 5'b00000, 5'b00011, 5'b11100, 1'b1, 3'd2};
    tbl[8]  = '{5'b00000, 5'b00000, 5'b00011, 5'b11100, 1'b1, 3'd2};
    tbl[9]  = '{5'b00000, 5'b00000, 5'b00011, 5'b11100, 1'b1, 3'd2};
    tbl[10] = '{5'b00000, 5'b00000, 5'b00011, 5'b11100, 1'b1, 3'd2};
    tbl[11] = '{5'b00000, 5'b00000, 5'b00011, 5'b11100, 1'b0, 3'd2};
    tbl[12] = '{5'b00000, 5'b00000, 5'b00011, 5'b11100, 1'b0, 3'd2};
    tbl[13] = '{5'b00000, 5'b00010, 5'b00001, 5'b11100, 1'b0, 3'd1};
    // Coffee maker granted; with the age-out the still-waiting washer/dishwasher expire on this edge.
    tbl[14] = '{5'b00000, 5'b00000, 5'b00101, TO_EN ? 5'b00000 : 5'b11000, 1'b1, 3'd2};

    rst = 1'b1; bus.on_req = '0; bus.off_req = '0;
    do_reset();
    chk("reset_cmd", 32'(dut_cmd()), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].on, tbl[i].off, "tbl_model");
      chk($sformatf("tbl%0d_cmd", i),  32'(dut_cmd()),        32'(tbl[i].cmd));
      chk($sformatf("tbl%0d_pend", i), 32'(bus.pending),      32'(tbl[i].pend));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy),         32'(tbl[i].busy));
      chk($sformatf("tbl%0d_cnt", i),  32'(bus.active_count), 32'(tbl[i].cnt));
    end

    // Stagger and priority from an all-at-once request.
    do_reset();
    fr = -1; ov = -1;
    step(5'b11111, 5'b00000, "prio");
    for (int c = 1; c <= 12; c++) begin
      step(5'b00000, 5'b00000, "prio");
      if (fr < 0 && bus.fridge_cmd) fr = c;
      if (ov < 0 && bus.oven_cmd) ov = c;
    end
    chk("prio_fridge_edge", 32'(fr), 32'd1);
    chk("prio_oven_gap", 32'(ov - fr), 32'd5);
    chk("prio_hold_count", 32'(bus.active_count), 32'd2);

    // Asynchronous reset in the middle of the hold-off window.
    do_reset();
    step(5'b00001, 5'b00000, "arst");
    step(5'b00000, 5'b00000, "arst");
    chk("arst_pre_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cmd", 32'(dut_cmd()), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_pend", 32'(bus.pending), 32'd0);
    chk("arst_count", 32'(bus.active_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Same-cycle on/off, then off on a pending-only bit while the budget is full.
    step(5'b01000, 5'b01000, "conf");
    chk("conf_washer", 32'(bus.washer_cmd), 32'd0);
    chk("conf_pend3", 32'(bus.pending[3]), 32'd0);
    step(5'b00011, 5'b00000, "conf");
    for (int c = 0; c < 7; c++) step(5'b00000, 5'b00000, "conf");
    chk("conf_full", 32'(bus.active_count), 32'd2);
    step(5'b10000, 5'b00000, "conf");
    chk("conf_pend4_set", 32'(bus.pending[4]), 32'd1);
    step(5'b00000, 5'b10000, "conf");
    chk("conf_pend4_clr", 32'(bus.pending[4]), 32'd0);
    for (int c = 0; c < 4; c++) step(5'b00000, 5'b00000, "conf");

    // Budget full: dishwasher request either ages out or waits forever.
    hi = 0; dr = 0;
    step(5'b10000, 5'b00000, "tmo");
    for (int c = 0; c < 12; c++) begin
      if (bus.pending[4]) hi++;
      step(5'b00000, 5'b00000, "tmo");
`ifdef PENDING_TIMEOUT_EN
      if (bus.drop[4]) dr++;
`endif
    end
`ifdef PENDING_TIMEOUT_EN
    chk("tmo_pending_cycles", 32'(hi), 32'(T));
    chk("tmo_drop_pulses", 32'(dr), 32'd1);
`else
    chk("tmo_pending_cycles", 32'(hi), 32'd12);
    chk("tmo_still_pending", 32'(bus.pending[4]), 32'd1);
    chk("tmo_no_drop", 32'(dr), 32'd0);
`endif

    // Randomized traffic against the timeline model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      on  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      off = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      step(on, off, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/appliance_cmd_scheduler.md
Name: appliance_cmd_scheduler

Overview:
- Upstream stage of smart_appliances_control. Turns user/app on/off request pulses into the five level-type appliance commands (fridge_cmd, oven_cmd, coffee_maker_cmd, washer_cmd, dishwasher_cmd).
- Enforces a household power budget: at most MAX_ACTIVE appliances commanded on at once.
- Staggers turn-ons by STAGGER_CYCLES to limit inrush current.
- Queues requests that cannot be granted immediately.

Parameters:
- MAX_ACTIVE, 2, maximum number of cmd outputs high simultaneously (1..5).
- STAGGER_CYCLES, 4, minimum cycles between consecutive turn-on grants (>=1).
- TIMEOUT_CYCLES, 64, pending-request lifetime in cycles (used only with PENDING_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- on_req  input  5  one-cycle turn-on request pulses; bit 0 fridge, 1 oven, 2 coffee_maker, 3 washer, 4 dishwasher
- off_req  input  5  one-cycle turn-off request pulses, same bit mapping
- fridge_cmd  output  1  command level to downstream block
- oven_cmd  output  1  command level to downstream block
- coffee_maker_cmd  output  1  command level to downstream block
- washer_cmd  output  1  command level to downstream block
- dishwasher_cmd  output  1  command level to downstream block
- pending  output  5  queued, not-yet-granted turn-on requests
- active_count  output  3  number of cmd outputs currently high
- busy  output  1  high while in stagger hold-off
- drop  output  5  one-cycle pulse when a pending request times out (present only with PENDING_TIMEOUT_EN)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all cmd outputs 0, pending 0, active_count 0, busy 0, drop 0; state IDLE; stagger counter 0.
- Reset mid-operation clears everything immediately. Requests in flight are lost.
- Internal cmd vector cmd[4:0] drives the five cmd ports.
- active_count is the combinational popcount of cmd.
- on_req[i]:
  - If cmd[i]=1 or pending[i]=1: ignored.
  - Otherwise pending[i] is set at the next edge.
- off_req[i]: clears cmd[i] and pending[i] at the next edge.
  - off_req[i] and on_req[i] in the same cycle: off wins; bit i ends with cmd 0, pending 0.
- FSM states: IDLE, HOLDOFF.
- IDLE, when pending!=0 and active_count<MAX_ACTIVE:
  - Grant the lowest-index pending bit (fridge highest priority).
  - Set cmd[k], clear pending[k].
  - Load counter = STAGGER_CYCLES-1; go HOLDOFF.
  - At most one grant per cycle.
- Grant latency: on_req sampled at edge N sets pending at N; cmd rises at edge N+1 (if IDLE and budget free).
- Budget check uses active_count before the edge.
  - An off_req in the same cycle does not free a slot until the following cycle.
  - Budget is never exceeded, even transiently.
- Granted bit k with off_req[k] in the same cycle: off wins; cmd[k] stays 0. The grant is still consumed and HOLDOFF is still entered.
- HOLDOFF: busy=1; no grants.
  - Counter decrements each cycle; at 0 return to IDLE.
  - Spacing between two grant edges is exactly STAGGER_CYCLES+1 cycles minimum.
  - off_req and on_req (queueing) are processed normally in HOLDOFF.
- Budget full (active_count==MAX_ACTIVE): requests stay pending indefinitely until a slot frees, or until timeout if PENDING_TIMEOUT_EN is defined.
- All outputs are registered except active_count.

Optional Feature:
- Macro: PENDING_TIMEOUT_EN.
- Defined:
  - Each appliance has an age counter ($clog2(TIMEOUT_CYCLES+1) bits), cleared when pending[i] sets.
  - Counter increments each cycle while pending[i]=1.
  - When it reaches TIMEOUT_CYCLES, pending[i] clears and drop[i] pulses high for one cycle.
  - If the grant and the timeout hit the same bit in the same cycle, the grant wins and there is no drop.
- Not defined: no age counters, no drop port; pending requests never expire.

Test Plan (MAX_ACTIVE=2, STAGGER_CYCLES=4, TIMEOUT_CYCLES=64 unless stated):
- Reset then idle: rst=1 for 2 cycles, then 0 -> all cmd 0, pending 0, active_count 0, busy 0. Assert rst mid-HOLDOFF -> all outputs 0 immediately (asynchronous).
- Single request: on_req=5'b00001 one cycle -> pending[0]=1 at the next edge; fridge_cmd=1 one edge later; busy=1 for 4 cycles.
- Stagger and priority: on_req=5'b11111 in one cycle -> fridge granted, oven granted 5 cycles later. Then active_count=2 and pending=5'b11100 hold.
- Budget release: with fridge and oven on, off_req=5'b00010 -> oven_cmd 0 next edge; coffee_maker_cmd 1 one edge after that (HOLDOFF already expired).
- Same-cycle conflict: on_req[3] and off_req[3] together -> washer_cmd 0, pending[3] 0. off_req on a pending-only bit -> pending bit cleared, never granted.
- Timeout (PENDING_TIMEOUT_EN, TIMEOUT_CYCLES=8): budget full, on_req[4] -> pending[4] clears after 8 cycles with drop[4] a single-cycle pulse. Without the macro, pending[4] remains set.
